hazard_stall_ctrl: RTL

Producer-side hazard controller for the 5-stage RV32I pipeline. It is the counterpart of the EX-stage forwarding logic: it detects the hazards that forwarding cannot cover, and drives stall, bubble and freeze controls to the PC and the pipeline registers. It covers three cases:
- load-use hazards;
- taken-branch flushes;
- multi-cycle data-memory waits, with a timeout fault.
It sits in the ID stage. It also exports saturating performance counters.

---
 rtl/hazard_stall_ctrl_pkg.sv | 21 ++
 rtl/hazard_stall_ctrl_sat_counter.sv | 33 +++
 rtl/hazard_stall_ctrl.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/hazard_stall_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_stall_ctrl_pkg
//  Description : Shared definitions for the ID-stage hazard/stall controller.
//                It holds the controller FSM encoding and the architectural
//                zero-register index.
//  Revision    : 1.0 - initial release
// ============================================================================
package hazard_stall_ctrl_pkg;

    typedef enum logic [1:0] {
        HZ_RUN      = 2'd0,
        HZ_MEM_WAIT = 2'd1,
        HZ_FAULT    = 2'd2
    } hz_state_e;

    // x0 is hard-wired to zero, so it never carries a real dependency.
    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage : hazard_stall_ctrl_pkg
`default_nettype wire

// File: rtl/hazard_stall_ctrl_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter
//  Description : Up-counter that sticks at all-ones instead of wrapping.
//  Ports       : clk   - clock, rising edge
//                rst   - asynchronous reset, active-high
//                inc   - count this cycle
//                count - current count value
//  Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (inc && (r_count != {W{1'b1}})) begin
            r_count <= r_count + W'(1);
        end
    end

    assign count = r_count;

endmodule : sat_counter
`default_nettype wire

// File: rtl/hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_stall_ctrl
//  Description : ID-stage hazard controller for the 5-stage RV32I pipeline.
//                It handles load-use stalls, taken-branch flushes and
//                data-memory wait freezes, and it raises a sticky fault when a
//                memory access waits too long. It also exports saturating
//                stall and flush counters.
//  Ports       : clk, rst                     - clock / async active-high reset
//                IF_ID_rs1/rs2, use_rs1/rs2   - source operands of the ID instr
//                ID_EX_MemRead, ID_EX_rd      - load in EX and its destination
//                EX_branch_taken              - EX redirects the PC
//                EX_MEM_MemAccess, dmem_ready - MEM access and its completion
//                PC_Write .. EX_MEM_Write     - pipeline register enables
//                IF_ID/ID_EX/MEM_WB_Flush     - bubble insertion controls
//                mem_err                      - sticky dmem timeout fault
//                stall_cycles, flush_count    - saturating perf counters
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       IF_ID_rs1,
    input  logic [4:0]       IF_ID_rs2,
    input  logic             IF_ID_use_rs1,
    input  logic             IF_ID_use_rs2,
    input  logic             ID_EX_MemRead,
    input  logic [4:0]       ID_EX_rd,
    input  logic             EX_branch_taken,
    input  logic             EX_MEM_MemAccess,
    input  logic             dmem_ready,
    output logic             PC_Write,
    output logic             IF_ID_Write,
    output logic             ID_EX_Write,
    output logic             EX_MEM_Write,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Flush,
    output logic             MEM_WB_Flush,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam int WAIT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] c_TIMEOUT  = WAIT_W'(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] c_WAIT_MAX = {WAIT_W{1'b1}};

    hz_state_e          r_state;
    hz_state_e          w_state_nxt;
    logic [WAIT_W-1:0]  r_wait_cnt;
    logic [WAIT_W-1:0]  w_wait_nxt;
    logic               r_mem_err;
    logic               w_err_nxt;

    logic               w_freeze;
    logic               w_load_use;
    logic               w_branch_apply;
    logic               w_lu_apply;

    // ------------------------------------------------------------------
    // Hazard detection
    // ------------------------------------------------------------------
    // A MEM access that is not ready freezes the pipe in the very cycle it
    // is seen in RUN, before the FSM has moved to MEM_WAIT.
    assign w_freeze = ((r_state == HZ_RUN)      && EX_MEM_MemAccess && !dmem_ready) ||
                      ((r_state == HZ_MEM_WAIT) && !dmem_ready) ||
                      (r_state == HZ_FAULT);

    assign w_load_use = ID_EX_MemRead && (ID_EX_rd != REG_ZERO) &&
                        ((IF_ID_use_rs1 && (IF_ID_rs1 == ID_EX_rd)) ||
                         (IF_ID_use_rs2 && (IF_ID_rs2 == ID_EX_rd)));

    // A taken branch makes the ID instruction wrong-path, so its load-use
    // stall is pointless and is dropped. Freeze holds the branch in EX so
    // it is applied only once the pipe is released.
    assign w_branch_apply = !w_freeze && EX_branch_taken;
    assign w_lu_apply     = !w_freeze && !EX_branch_taken && w_load_use;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= HZ_RUN;
            r_wait_cnt <= '0;
            r_mem_err  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_nxt;
            r_mem_err  <= w_err_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_wait_nxt  = r_wait_cnt;
        w_err_nxt   = r_mem_err;
        case (r_state)
            HZ_RUN: begin
                if (EX_MEM_MemAccess && !dmem_ready) begin
                    w_state_nxt = HZ_MEM_WAIT;
                    w_wait_nxt  = WAIT_W'(1);
                end
            end
            HZ_MEM_WAIT: begin
                if (dmem_ready) begin
                    w_state_nxt = HZ_RUN;
                    w_wait_nxt  = '0;
                end else if ((MEM_TIMEOUT != 0) && (r_wait_cnt == c_TIMEOUT)) begin
                    w_state_nxt = HZ_FAULT;
                    w_err_nxt   = 1'b1;
                end else if (r_wait_cnt != c_WAIT_MAX) begin
                    // Held at all-ones when the timeout is disabled.
                    w_wait_nxt = r_wait_cnt + WAIT_W'(1);
                end
            end
            HZ_FAULT: begin
                // Only reset leaves FAULT; dmem_ready is ignored here.
            end
            default: begin
                w_state_nxt = HZ_RUN;
                w_wait_nxt  = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Pipeline controls (Mealy). Reset forces every enable and flush low.
    // ------------------------------------------------------------------
    always_comb begin
        PC_Write     = 1'b0;
        IF_ID_Write  = 1'b0;
        ID_EX_Write  = 1'b0;
        EX_MEM_Write = 1'b0;
        IF_ID_Flush  = 1'b0;
        ID_EX_Flush  = 1'b0;
        MEM_WB_Flush = 1'b0;
        if (!rst) begin
            if (w_freeze) begin
                // Everything up to EX/MEM holds; MEM/WB takes a bubble so the
                // stalled access does not retire twice.
                MEM_WB_Flush = 1'b1;
            end else if (w_branch_apply) begin
                PC_Write     = 1'b1;
                IF_ID_Write  = 1'b1;
                ID_EX_Write  = 1'b1;
                EX_MEM_Write = 1'b1;
                IF_ID_Flush  = 1'b1;
                ID_EX_Flush  = 1'b1;
            end else if (w_lu_apply) begin
                ID_EX_Write  = 1'b1;
                EX_MEM_Write = 1'b1;
                ID_EX_Flush  = 1'b1;
            end else begin
                PC_Write     = 1'b1;
                IF_ID_Write  = 1'b1;
                ID_EX_Write  = 1'b1;
                EX_MEM_Write = 1'b1;
            end
        end
    end

    assign mem_err = r_mem_err;

    // ------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------
    logic w_stall_inc;
    logic w_flush_inc;

    assign w_stall_inc = (w_freeze || w_lu_apply) && (r_state != HZ_FAULT);
    assign w_flush_inc = w_branch_apply;

    sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_stall_inc),
        .count (stall_cycles)
    );

    sat_counter #(
        .W (CNT_W)
    ) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_flush_inc),
        .count (flush_count)
    );

endmodule : hazard_stall_ctrl
`default_nettype wire
